// File: rtl/sample02_pkg.sv
// Shared constants for the sample02 lane-parallel pipelined evaluator.
package sample02_pkg;

  localparam int unsigned LATENCY = 3;
  localparam int unsigned W_MAX   = 64;

endpackage

// File: rtl/sample02_pipe_stage.sv
// Generic valid/data register slice; loads when empty or when downstream advances.
module sample02_pipe_stage #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [DW-1:0] data_in,
  input  logic          down_en,
  output logic          valid,
  output logic [DW-1:0] data_out,
  output logic          en
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  assign en       = ~r_valid | down_en;
  assign valid    = r_valid;
  assign data_out = r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (en) begin
      r_valid <= up_valid;
      r_data  <= data_in;
    end
  end

endmodule

// File: rtl/sample02_pipe.sv
// Three-stage valid/ready pipeline computing o = !(d&e&k), p = !k per lane,
// with k = (c|a|b|(b&d)) & (e|a|b|(b&d)).
module sample02_pipe
  import sample02_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [W-1:0] e,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] o,
  output logic [W-1:0] p
);

  // Structs live here because their width follows the W parameter.
  typedef struct packed {
    logic [W-1:0] c;
    logic [W-1:0] h;
    logic [W-1:0] j;
    logic [W-1:0] m;
  } s1_t;

  typedef struct packed {
    logic [W-1:0] k;
    logic [W-1:0] m;
  } s2_t;

  typedef struct packed {
    logic [W-1:0] o;
    logic [W-1:0] p;
  } s3_t;

  s1_t          w_s1_d, w_s1_q;
  s2_t          w_s2_d, w_s2_q;
  s3_t          w_s3_d, w_s3_q;
  logic         w_v1, w_v2, w_v3;
  logic         w_en1, w_en2, w_en3;
  logic [W-1:0] w_f, w_g;

  assign w_f      = a | b;
  assign w_g      = b & d;
  assign w_s1_d.c = c;
  assign w_s1_d.h = w_f | w_g;
  assign w_s1_d.j = e | w_f | w_g;
  assign w_s1_d.m = d & e;

  assign w_s2_d.k = (w_s1_q.c | w_s1_q.h) & w_s1_q.j;
  assign w_s2_d.m = w_s1_q.m;

  assign w_s3_d.o = ~(w_s2_q.m & w_s2_q.k);
  assign w_s3_d.p = ~w_s2_q.k;

  sample02_pipe_stage #(.DW($bits(s1_t))) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (in_valid),
    .data_in  (w_s1_d),
    .down_en  (w_en2),
    .valid    (w_v1),
    .data_out (w_s1_q),
    .en       (w_en1)
  );

  sample02_pipe_stage #(.DW($bits(s2_t))) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (w_v1),
    .data_in  (w_s2_d),
    .down_en  (w_en3),
    .valid    (w_v2),
    .data_out (w_s2_q),
    .en       (w_en2)
  );

  sample02_pipe_stage #(.DW($bits(s3_t))) u_s3 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (w_v2),
    .data_in  (w_s3_d),
    .down_en  (out_ready),
    .valid    (w_v3),
    .data_out (w_s3_q),
    .en       (w_en3)
  );

  assign in_ready  = w_en1;
  assign out_valid = w_v3;
  assign o         = w_s3_q.o;
  assign p         = w_s3_q.p;

endmodule
